// File: rtl/tdc_therm_decoder_pipe.sv
// Three-stage delay-line thermometer decoder: capture/polarity, bubble correction,
// popcount with saturation and malformed-code flag, under valid/ready back-pressure.
module tdc_therm_decoder_pipe #(
   parameter int TAP_W     = 32,
   parameter int FINE_W    = 5,
   parameter bit BUBBLE_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [TAP_W-1:0]  data_in,
   input  logic              pol,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [FINE_W-1:0] fine_code,
   output logic              sat,
   output logic              err
);

   localparam int          CNT_W    = $clog2(TAP_W + 1);
   localparam logic [31:0] MAX_CODE = (32'd1 << FINE_W) - 32'd1;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic [CNT_W-1:0] popcnt(input logic [TAP_W-1:0] v);
      logic [CNT_W-1:0] acc;
      acc = {CNT_W{1'b0}};
      for (int i = 0; i < TAP_W; i++) begin
         acc = acc + {{(CNT_W-1){1'b0}}, v[i]};
      end
      return acc;
   endfunction

   logic              init_r;
   logic              v1_r, v2_r, v3_r;
   logic              en1_s, en2_s, en3_s;
   logic [TAP_W-1:0]  t_r;
   logic [TAP_W-1:0]  c_r;
   logic [TAP_W-1:0]  c_s;
   logic [TAP_W+1:0]  tp_s;
   logic [CNT_W-1:0]  cnt_s;
   logic [31:0]       cnt_ext_s;
   logic [FINE_W-1:0] code_s;
   logic              sat_s;
   logic              err_s;
   logic [FINE_W-1:0] code_r;
   logic              sat_r;
   logic              err_r;

   // A stage loads when it is empty or its content moves on, so bubbles collapse.
   assign en3_s     = ~v3_r | out_rdy;
   assign en2_s     = ~v2_r | en3_s;
   assign en1_s     = ~v1_r | en2_s;
   assign in_rdy    = init_r & en1_s;
   assign out_vld   = v3_r;
   assign fine_code = code_r;
   assign sat       = sat_r;
   assign err       = err_r;

   // Bubble correction: 3-tap majority with the end taps replicated.
   always_comb begin
      tp_s = {t_r[TAP_W-1], t_r, t_r[0]};
      c_s  = t_r;
      if (BUBBLE_EN) begin
         for (int i = 0; i < TAP_W; i++) begin
            c_s[i] = maj3(tp_s[i], tp_s[i+1], tp_s[i+2]);
         end
      end else begin
         c_s = t_r;
      end
   end

   // Count, saturate and detect any 0-then-1 step in the corrected taps.
   always_comb begin
      cnt_s     = popcnt(c_r);
      cnt_ext_s = 32'(cnt_s);
      sat_s     = (cnt_ext_s > MAX_CODE);
      code_s    = cnt_ext_s[FINE_W-1:0];
      if (sat_s) begin
         code_s = MAX_CODE[FINE_W-1:0];
      end else begin
         code_s = cnt_ext_s[FINE_W-1:0];
      end
      err_s = |(~c_r[TAP_W-2:0] & c_r[TAP_W-1:1]);
   end

   // Pipeline occupancy and the post-reset ready enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_r <= 1'b0;
         v1_r   <= 1'b0;
         v2_r   <= 1'b0;
         v3_r   <= 1'b0;
      end else begin
         init_r <= 1'b1;
         if (en1_s) v1_r <= in_vld & init_r;
         if (en2_s) v2_r <= v1_r;
         if (en3_s) v3_r <= v2_r;
      end
   end

   // Stage data registers; each holds while its stage is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_r    <= {TAP_W{1'b0}};
         c_r    <= {TAP_W{1'b0}};
         code_r <= {FINE_W{1'b0}};
         sat_r  <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         if (en1_s) t_r <= data_in ^ {TAP_W{pol}};
         if (en2_s) c_r <= c_s;
         if (en3_s) begin
            code_r <= code_s;
            sat_r  <= sat_s;
            err_r  <= err_s;
         end
      end
   end

endmodule

// File: doc/tdc_therm_decoder_pipe.md
Name: tdc_therm_decoder_pipe

Overview:
- Parametrised, pipelined successor to the TDC SPAD fine-time decoder.
- Converts a sampled delay-line thermometer code into a binary fine-time code. Bubble-corrects the taps, flags malformed or saturated codes, and supports rising/falling edge polarity per sample.
- Sits between the delay-line sampling flops and the timestamp assembler. Uses a valid/ready handshake with full back-pressure.

Parameters:
- TAP_W, 32, number of delay-line taps in data_in; must be ≥4.
- FINE_W, 5, width of fine_code; count saturates at 2^FINE_W-1.
- BUBBLE_EN, 1, 1 = 3-tap majority bubble correction enabled; 0 = bypass.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_vld  in  1  sample valid.
- in_rdy  out  1  block can accept a sample this cycle.
- data_in  in  TAP_W  sampled taps; tap 0 = first tap hit by the edge.
- pol  in  1  0 = rising edge (ones propagate); 1 = falling edge (taps inverted before decode). Sampled with data_in.
- out_vld  out  1  result valid.
- out_rdy  in  1  downstream accepts result.
- fine_code  out  FINE_W  count of ones after correction, saturated.
- sat  out  1  count exceeded 2^FINE_W-1.
- err  out  1  corrected pattern not of form 1…10…0.

Behaviour:
- Reset: all pipeline valid bits 0, all data registers 0. Outputs: out_vld=0, fine_code=0, sat=0, err=0. in_rdy is 1 one cycle after rst_n deasserts. Reset may assert at any cycle; in-flight samples are discarded, not flushed.
- Handshake: a transfer occurs when vld&rdy on a rising clk edge. Outputs hold stable while out_vld=1 and out_rdy=0.
- Pipeline: 3 stages, S1 capture, S2 correct, S3 count/flag. Latency is 3 cycles from input transfer to out_vld with no stall. Throughput is 1 sample/cycle.
- Stall rule: stall = out_vld & ~out_rdy.
  - Stalled stages hold.
  - in_rdy = ~stall OR any pipeline bubble exists upstream of S3. Bubbles collapse: a stage loads whenever the stage after it is empty or advancing.
  - No sample is dropped or duplicated.
- S1: register t = data_in XOR {TAP_W{pol}}.
- S2, BUBBLE_EN=1: corrected tap c[i] = majority(t[i-1], t[i], t[i+1]), with t[-1]=t[0] and t[TAP_W]=t[TAP_W-1]. BUBBLE_EN=0: c=t.
- S3:
  - n = popcount(c), computed at $clog2(TAP_W+1) bits.
  - fine_code = min(n, 2^FINE_W-1).
  - sat = (n > 2^FINE_W-1).
  - err = 1 if any i with c[i]=0 and c[i+1]=1.
  - fine_code is still driven when err=1 (popcount value).
- Boundaries:
  - All-zero taps → fine_code=0, err=0, sat=0.
  - All-one taps with TAP_W=32, FINE_W=5 → fine_code=31, sat=1, err=0.
  - Single isolated bubble is removed, no err.
  - Two adjacent bubbles survive majority → err=1.
  - in_vld dropping mid-stream creates bubbles that are collapsed by the stall rule.
  - out_rdy held low forever: pipeline fills to 3 entries, then in_rdy=0.

Test Plan:
- Reset then data_in=32'h0000_FFFF, pol=0, out_rdy=1 → 3 cycles later out_vld=1, fine_code=16, err=0, sat=0.
- data_in=32'hFFFF_0000, pol=1 → fine_code=16, err=0. Same data_in with pol=0 → err=1, fine_code=16.
- Bubble: data_in=32'h0000_0FDF (tap5=0 inside ones) → fine_code=12, err=0. Same with BUBBLE_EN=0 → fine_code=11, err=1.
- Saturation: data_in=32'hFFFF_FFFF, pol=0 → fine_code=31, sat=1. data_in=0 → fine_code=0, sat=0.
- Back-pressure: stream 8 samples with counts 1..8 back-to-back while out_rdy toggles 1,0,0,1,…
  - Required: all 8 delivered in order with exact counts.
  - in_rdy=0 only when 3 entries are held.
  - Outputs stable during stall.
- Reset mid-stream: assert rst_n=0 with 3 samples in flight → out_vld=0 immediately (asynchronous). After release, no stale result appears; the next sample returns in 3 cycles.
